// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: sequencer for the multi-cycle multiply/divide unit in Execute.
// Runs a WIDTH-iteration shift-add multiply or restoring divide on the
// operands captured at start, and stalls the pipeline while it works.
// Ports:
//   CLK, RESETn       clock, synchronous active-low reset
//   MCycleStartE      start request from the E pipeline register
//   MCycleOpE         00 smul, 01 umul, 10 sdiv, 11 udiv
//   Operand1/2        multiplicand/dividend, multiplier/divisor
//   Busy              combinational stall request (start cycle + COMPUTE)
//   Done              one-cycle pulse when Result1/Result2 are valid
//   Result1/2         product low/high word, or quotient/remainder
module mcycle_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             MCycleStartE,
    input  logic [1:0]       MCycleOpE,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    count;
    logic             op_div;
    logic             neg_q;      // product / quotient must be negated
    logic             neg_r;      // remainder takes the (negative) dividend sign
    logic [WIDTH-1:0] opnd;       // multiplicand for MUL, divisor for DIV
    logic [AW-1:0]    acc;        // {hi, lo} product or {rem, quot}

    logic             sgn_op;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [AW-1:0]    acc_n;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;
    logic             last_iter;

    // Operand magnitudes; the most-negative value maps to itself as unsigned.
    always_comb begin
        sgn_op = ~MCycleOpE[0];
        abs1   = (sgn_op && Operand1[WIDTH-1]) ? WIDTH'(-Operand1) : Operand1;
        abs2   = (sgn_op && Operand2[WIDTH-1]) ? WIDTH'(-Operand2) : Operand2;
    end

    // One iteration of either algorithm, plus sign-corrected final values.
    always_comb begin
        mul_sum = {1'b0, acc[AW-1:WIDTH]} + {1'b0, opnd};
        // Shifted remainder needs a carry bit when the divisor has its MSB set.
        rem_sh  = acc[AW-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd};
        acc_n   = '0;
        if (op_div) begin
            if (diff[WIDTH]) acc_n = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else             acc_n = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            if (acc[0]) acc_n = {mul_sum, acc[WIDTH-1:1]};
            else        acc_n = {1'b0, acc[AW-1:1]};
        end

        prod_fix = neg_q ? AW'(-acc_n) : acc_n;
        // Divide by zero leaves quotient magnitude all ones; force it so the
        // sign correction cannot flip it.
        if (opnd == '0)  quot_fix = '1;
        else if (neg_q)  quot_fix = WIDTH'(-acc_n[WIDTH-1:0]);
        else             quot_fix = acc_n[WIDTH-1:0];
        rem_fix = neg_r ? WIDTH'(-acc_n[AW-1:WIDTH]) : acc_n[AW-1:WIDTH];
    end

    assign last_iter = (count == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESETn) state <= S_IDLE;
        else         state <= state_n;
    end

    // Next state and status outputs; DONE ignores a held start request.
    always_comb begin
        state_n = state;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (MCycleStartE) begin
                    Busy    = 1'b1;
                    state_n = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                Busy = 1'b1;
                if (last_iter) state_n = S_DONE;
            end
            S_DONE: begin
                Done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: capture at start, iterate, register results on DONE entry.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            count   <= '0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MCycleStartE) begin
                        count  <= '0;
                        op_div <= MCycleOpE[1];
                        neg_q  <= sgn_op & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                        neg_r  <= sgn_op & Operand1[WIDTH-1];
                        if (MCycleOpE[1]) begin
                            opnd <= abs2;
                            acc  <= {{WIDTH{1'b0}}, abs1};
                        end else begin
                            opnd <= abs1;
                            acc  <= {{WIDTH{1'b0}}, abs2};
                        end
                    end
                end
                S_COMPUTE: begin
                    acc   <= acc_n;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        if (op_div) begin
                            Result1 <= quot_fix;
                            Result2 <= rem_fix;
                        end else begin
                            Result1 <= prod_fix[WIDTH-1:0];
                            Result2 <= prod_fix[AW-1:WIDTH];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
